// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demultiplexer: FSM encodings, lane indices
// and the word counter width.
package demux_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    localparam int WCNT_W = 8;

    function automatic logic [3:0] lane_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: a W-bit data register with write enable plus a registered
// strobe that pulses for the single cycle after each write.
module demux_lane #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] q_o,
    output logic         stb_o
);

    logic [W-1:0] data_q;
    logic         stb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= we_i;
            if (we_i) begin
                data_q <= din_i;
            end
        end
    end

    assign q_o   = data_q;
    assign stb_o = stb_q;

endmodule

// File: rtl/demux_1to4.sv
// Sequential 1-to-4 demultiplexer: manual lane select, or automatic collection
// of four beats into a word handed off with a valid/ready handshake.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              s1,
    input  logic              s0,
    input  logic [W-1:0]      f,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      a,
    output logic [W-1:0]      b,
    output logic [W-1:0]      c,
    output logic [W-1:0]      d,
    output logic [3:0]        strobe,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WCNT_W-1:0] word_cnt
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;

    logic              accept;
    logic [1:0]        lane_sel;
    logic [3:0]        lane_we;
    logic [W-1:0]      lane_q [4];

    // Both handshake outputs depend only on registered state.
    assign in_ready   = (state_q != HOLD);
    assign word_valid = (state_q == HOLD);
    assign accept     = in_valid & in_ready;

    assign lane_sel = (state_q == COLLECT) ? ptr_q : {s1, s0};
    assign lane_we  = accept ? lane_onehot(lane_sel) : 4'b0000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mode) begin
                    state_d = COLLECT;
                    ptr_d   = LANE_A;
                end
            end
            COLLECT: begin
                if (accept) begin
                    ptr_d = ptr_q + 2'd1;
                    if (ptr_q == LANE_D) begin
                        state_d = HOLD;
                    end
                end
                if (!mode) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // A hand-off coinciding with a mode drop still counts.
                if (word_ready) begin
                    cnt_d   = cnt_q + WCNT_W'(1);
                    state_d = COLLECT;
                    ptr_d   = LANE_A;
                end
                if (!mode) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = LANE_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= LANE_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            demux_lane #(.W(W)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .we_i  (lane_we[gi]),
                .din_i (f),
                .q_o   (lane_q[gi]),
                .stb_o (strobe[gi])
            );
        end
    endgenerate

    assign a        = lane_q[LANE_A];
    assign b        = lane_q[LANE_B];
    assign c        = lane_q[LANE_C];
    assign d        = lane_q[LANE_D];
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4 (W=1): per-cycle expected strobe/lane writes go
// through a scoreboard queue; state outputs are checked at each step.
module tb_demux_1to4;

    logic       clk;
    logic       rst_n;
    logic       mode, s1, s0;
    logic [0:0] f;
    logic       in_valid, in_ready;
    logic [0:0] a, b, c, d;
    logic [3:0] strobe;
    logic       word_valid, word_ready;
    logic [7:0] word_cnt;
    logic [3:0] lanes;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [3:0] stb;
        logic       val;
        int         lane;
    } exp_t;
    exp_t sb[$];

    demux_1to4 #(.W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .s1         (s1),
        .s0         (s0),
        .f          (f),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .strobe     (strobe),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_cnt   (word_cnt)
    );

    assign lanes = {d, c, b, a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push this cycle's expected write, clock once, then pop and compare.
    task automatic tick(input bit acc, input int lane, input logic val);
        exp_t e;
        e.stb  = acc ? (4'b0001 << lane) : 4'b0000;
        e.val  = val;
        e.lane = lane;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("strobe", {28'd0, strobe}, {28'd0, e.stb});
        if (e.stb != 4'b0000) begin
            chk("lane_data", {31'd0, lanes[e.lane]}, {31'd0, e.val});
        end
    endtask

    task automatic sel(input int lane);
        {s1, s0} = 2'(lane);
    endtask

    logic [3:0] mpat;
    logic [3:0] apat;

    initial begin
        mpat = 4'b1101;
        apat = 4'b1011;
        rst_n = 1'b0;
        {mode, s1, s0, f, in_valid, word_ready} = '0;

        // Reset with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            {mode, s1, s0, f, in_valid, word_ready} = 6'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_lanes", {28'd0, lanes}, 32'd0);
        chk("rst_strobe", {28'd0, strobe}, 32'd0);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
        {mode, s1, s0, f, in_valid, word_ready} = '0;
        rst_n = 1'b1;
        tick(0, 0, 1'b0);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Manual routing.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel(i);
            f = mpat[i];
            tick(1, i, mpat[i]);
            chk("man_word_valid", {31'd0, word_valid}, 32'd0);
        end
        chk("man_lanes", {28'd0, lanes}, {28'd0, mpat});

        // Auto word with back-pressure.
        in_valid = 1'b0;
        mode = 1'b1;
        sel(2);
        tick(0, 0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f = apat[i];
            tick(1, i, apat[i]);
            if (i < 3) chk("auto_wv_early", {31'd0, word_valid}, 32'd0);
        end
        chk("auto_wv", {31'd0, word_valid}, 32'd1);
        chk("auto_word", {28'd0, lanes}, {28'd0, apat});
        f = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1'b0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_wv", {31'd0, word_valid}, 32'd1);
            chk("bp_lanes", {28'd0, lanes}, {28'd0, apat});
        end
        in_valid = 1'b0;
        word_ready = 1'b1;
        tick(0, 0, 1'b0);
        word_ready = 1'b0;
        chk("hs_cnt", {24'd0, word_cnt}, 32'd1);
        chk("hs_wv", {31'd0, word_valid}, 32'd0);
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);

        // Back in COLLECT: select lines ignored, two beats then mode drop.
        in_valid = 1'b1;
        sel(3);
        f = 1'b0;
        tick(1, 0, 1'b0);
        f = 1'b1;
        tick(1, 1, 1'b1);
        in_valid = 1'b0;
        mode = 1'b0;
        tick(0, 0, 1'b0);
        chk("drop_wv", {31'd0, word_valid}, 32'd0);
        chk("drop_cnt", {24'd0, word_cnt}, 32'd1);
        chk("drop_a", {31'd0, a}, 32'd0);
        chk("drop_b", {31'd0, b}, 32'd1);
        in_valid = 1'b1;
        sel(2);
        f = 1'b1;
        tick(1, 2, 1'b1);
        chk("drop_wv_manual", {31'd0, word_valid}, 32'd0);

        // Reset while holding a complete word.
        in_valid = 1'b0;
        mode = 1'b1;
        tick(0, 0, 1'b0);
        in_valid = 1'b1;
        f = 1'b1;
        for (int i = 0; i < 4; i++) tick(1, i, 1'b1);
        chk("hold_wv", {31'd0, word_valid}, 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick(0, 0, 1'b0);
        chk("hrst_wv", {31'd0, word_valid}, 32'd0);
        chk("hrst_lanes", {28'd0, lanes}, 32'd0);
        chk("hrst_cnt", {24'd0, word_cnt}, 32'd0);
        rst_n = 1'b1;

        // 256 back-to-back words, word_ready tied high: one bubble per word.
        word_ready = 1'b1;
        exp_cnt = 8'd0;
        tick(0, 0, 1'b0);
        in_valid = 1'b1;
        for (int w = 0; w < 256; w++) begin
            for (int i = 0; i < 4; i++) begin
                f = 1'($urandom);
                tick(1, i, f[0]);
            end
            chk("wrap_wv", {31'd0, word_valid}, 32'd1);
            chk("wrap_in_ready", {31'd0, in_ready}, 32'd0);
            tick(0, 0, 1'b0);
            exp_cnt = exp_cnt + 8'd1;
            chk("wrap_cnt", {24'd0, word_cnt}, {24'd0, exp_cnt});
            chk("wrap_wv_low", {31'd0, word_valid}, 32'd0);
        end
        chk("wrap_final_zero", {24'd0, word_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
